// File: rtl/jtag_cmd_pkg.sv
// Shared opcodes, FSM encoding and status-word bit positions for the JTAG
// command sequencer.
package jtag_cmd_pkg;
  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_SETADDR = 8'h01;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_STATUS  = 8'h04;
  localparam logic [7:0] OP_CLRERR  = 8'h05;
  localparam logic [7:0] OP_SETINC  = 8'h06;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUS = 1'b1} state_t;

  localparam int STAT_BUSY       = 0;
  localparam int STAT_BUSERR     = 1;
  localparam int STAT_TIMEOUT    = 2;
  localparam int STAT_OVERRUN    = 3;
  localparam int STAT_BADOP      = 4;
  localparam int STAT_AUTOINC    = 5;
  localparam int STAT_LASTOP_LSB = 8;
endpackage

// File: rtl/jtag_cmd_timer.sv
// Per-transaction cycle counter; saturates at TIMEOUT-1, which is also the
// expiry flag, so it can never wrap.
module jtag_cmd_timer #(
  parameter  int TIMEOUT = 255,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic tck,
  input  logic trst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);
  logic [CW-1:0] r_cnt;

  assign o_expired = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge tck or negedge trst) begin
    if (!trst)                     r_cnt <= '0;
    else if (i_clr)                r_cnt <= '0;
    else if (i_inc && !o_expired)  r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/jtag_cmd_sequencer.sv
// Turns TAP user-opcode strobes into valid/ready bus transactions with an
// auto-incrementing address pointer, per-transaction timeout and status word.
module jtag_cmd_sequencer
  import jtag_cmd_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 8,
  parameter int INC_STEP = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic              tck,
  input  logic              trst,
  input  logic [OP_W-1:0]   op_in,
  input  logic              op_strobe,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] rdata_out,
  output logic              busy,
  output logic              bus_valid,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err
);
  state_t             r_state, w_state_nxt;
  logic               r_strobe_q;
  logic [ADDR_W-1:0]  r_addr, r_bus_addr;
  logic [DATA_W-1:0]  r_bus_wdata, r_rdata;
  logic [OP_W-1:0]    r_last_op;
  logic               r_bus_write, r_autoinc;
  logic               r_buserr, r_timeout, r_overrun, r_badop;
  logic               w_cmd, w_is_bus, w_exec, w_ovr;
  logic               w_launch, w_done, w_abort, w_tinc, w_expired;
  logic [DATA_W-1:0]  w_status;

  assign w_cmd    = op_strobe & ~r_strobe_q;
  assign w_is_bus = (op_in == OP_W'(OP_WRITE)) || (op_in == OP_W'(OP_READ));
  assign w_exec   = w_cmd && (r_state == ST_IDLE) && !w_is_bus;
  assign w_ovr    = w_cmd && (r_state == ST_BUS);

  // Valid is decoded from state so an async reset drops it immediately.
  assign bus_valid = (r_state == ST_BUS);
  assign busy      = (r_state == ST_BUS);
  assign bus_write = r_bus_write;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign rdata_out = r_rdata;

  jtag_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .tck       (tck),
    .trst      (trst),
    .i_clr     (w_launch),
    .i_inc     (w_tinc),
    .o_expired (w_expired)
  );

  always_comb begin
    w_status                           = '0;
    w_status[STAT_BUSY]                = busy;
    w_status[STAT_BUSERR]              = r_buserr;
    w_status[STAT_TIMEOUT]             = r_timeout;
    w_status[STAT_OVERRUN]             = r_overrun;
    w_status[STAT_BADOP]               = r_badop;
    w_status[STAT_AUTOINC]             = r_autoinc;
    w_status[STAT_LASTOP_LSB +: 8]     = r_last_op[7:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_tinc      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_cmd && w_is_bus) begin
        w_launch    = 1'b1;
        w_state_nxt = ST_BUS;
      end
      ST_BUS: begin
        if (bus_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_expired) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tinc      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_strobe_q  <= 1'b0;
      r_last_op   <= '0;
      r_addr      <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_write <= 1'b0;
      r_rdata     <= '0;
      r_autoinc   <= 1'b0;
      r_buserr    <= 1'b0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
      r_badop     <= 1'b0;
    end else begin
      r_strobe_q <= op_strobe;
      if (w_cmd) r_last_op <= op_in;
      if (w_launch) begin
        r_bus_addr  <= r_addr;
        r_bus_wdata <= wdata_in;
        r_bus_write <= (op_in == OP_W'(OP_WRITE));
      end
      if (w_exec) begin
        case (op_in)
          OP_W'(OP_NOP):     ;
          OP_W'(OP_SETADDR): r_addr    <= wdata_in[ADDR_W-1:0];
          OP_W'(OP_STATUS):  r_rdata   <= w_status;
          OP_W'(OP_SETINC):  r_autoinc <= wdata_in[0];
          OP_W'(OP_CLRERR): begin
            r_buserr  <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
            r_badop   <= 1'b0;
          end
          default:           r_badop   <= 1'b1;
        endcase
      end
      if (w_ovr) r_overrun <= 1'b1;
      if (w_done) begin
        if (!r_bus_write) r_rdata <= bus_rdata;
        // An errored transfer leaves the pointer where it was so it can be retried.
        if (bus_err)        r_buserr <= 1'b1;
        else if (r_autoinc) r_addr   <= r_addr + ADDR_W'(INC_STEP);
      end
      if (w_abort) r_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// Randomized scoreboard bench: a command-level model predicts bus requests and
// rdata_out; independent monitor processes compare against the DUT.
module tb_jtag_cmd_sequencer;
  localparam int TO = 4;

  logic        tck = 1'b0, trst = 1'b0, op_strobe = 1'b0;
  logic [7:0]  op_in = '0;
  logic [31:0] wdata_in = '0, bus_rdata = '0;
  logic        bus_ready = 1'b0, bus_err = 1'b0;
  logic [31:0] rdata_out, bus_addr, bus_wdata;
  logic        busy, bus_valid, bus_write;

  jtag_cmd_sequencer #(.ADDR_W(32), .DATA_W(32), .OP_W(8), .INC_STEP(4), .TIMEOUT(TO)) dut (
    .tck(tck), .trst(trst), .op_in(op_in), .op_strobe(op_strobe), .wdata_in(wdata_in),
    .rdata_out(rdata_out), .busy(busy), .bus_valid(bus_valid), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 tck = ~tck;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          len;   // 0: aborted by reset, length not checked
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_rd[$];
  req_t        cur;
  int          n_tests = 0, n_fail = 0;

  // Reference model state
  logic [31:0] m_addr, m_rdata;
  logic [7:0]  m_last;
  logic        m_autoinc, m_buserr, m_tmo, m_ovr, m_badop;

  // Responder configuration
  int          rsp_delay = 1;
  logic        rsp_err = 1'b0;
  logic [31:0] rsp_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_addr = '0; m_rdata = '0; m_last = '0;
    m_autoinc = 0; m_buserr = 0; m_tmo = 0; m_ovr = 0; m_badop = 0;
  endtask

  function automatic logic [31:0] m_status();
    return {16'd0, m_last, 2'd0, m_autoinc, m_badop, m_ovr, m_tmo, m_buserr, 1'b0};
  endfunction

  task automatic model_apply(input logic [7:0] op, input logic [31:0] wd);
    req_t r;
    bit   ok;
    case (op)
      8'h00: ;
      8'h01: m_addr = wd;
      8'h02, 8'h03: begin
        ok      = (rsp_delay >= 1) && (rsp_delay <= TO);
        r.addr  = m_addr;
        r.wr    = (op == 8'h02);
        r.wdata = wd;
        r.len   = ok ? rsp_delay : TO;
        exp_req.push_back(r);
        if (ok) begin
          if (op == 8'h03) m_rdata = rsp_rdata;
          if (rsp_err)        m_buserr = 1;
          else if (m_autoinc) m_addr = m_addr + 32'd4;
        end else m_tmo = 1;
      end
      8'h04: m_rdata = m_status();
      8'h05: begin m_buserr = 0; m_tmo = 0; m_ovr = 0; m_badop = 0; end
      8'h06: m_autoinc = wd[0];
      default: m_badop = 1;
    endcase
    m_last = op;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] wd);
    @(negedge tck);
    op_in = op; wdata_in = wd; op_strobe = 1'b1;
    @(negedge tck);
    op_strobe = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin @(negedge tck); n++; end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle busy stuck actual=1 expected=0");
    end
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] wd, input int d,
                         input logic e, input logic [31:0] rd);
    rsp_delay = d; rsp_err = e; rsp_rdata = rd;
    model_apply(op, wd);
    issue(op, wd);
    wait_idle();
    #1 exp_rd.push_back(m_rdata);
  endtask

  // Bus target: ready on the rsp_delay-th valid cycle (0 = never)
  initial begin
    int rcnt = 0;
    forever begin
      @(negedge tck);
      bus_rdata = rsp_rdata;
      bus_err   = rsp_err;
      if (bus_valid) begin
        rcnt++;
        bus_ready = (rcnt == rsp_delay);
      end else begin
        rcnt = 0;
        bus_ready = 1'b0;
      end
    end
  end

  // Monitor: bus requests and rdata_out snapshots
  initial begin
    logic prev_valid = 1'b0;
    int   len_cnt = 0;
    bit   have = 0;
    forever begin
      @(negedge tck);
      if (bus_valid && !prev_valid) begin
        len_cnt = 1;
        if (exp_req.size() == 0) begin
          have = 0;
          n_tests++; n_fail++;
          $display("FAIL unexpected_req actual=addr %h expected=no request", bus_addr);
        end else begin
          cur  = exp_req.pop_front();
          have = 1;
          chk("req_addr", bus_addr, cur.addr);
          chk("req_write", {31'd0, bus_write}, {31'd0, cur.wr});
          if (cur.wr) chk("req_wdata", bus_wdata, cur.wdata);
        end
      end else if (bus_valid) begin
        len_cnt++;
        if (have) chk("req_addr_stable", bus_addr, cur.addr);
      end else if (prev_valid && have && cur.len > 0) begin
        chk("req_len", len_cnt, cur.len);
      end
      prev_valid = bus_valid;
      while (exp_rd.size() > 0) chk("rdata_out", rdata_out, exp_rd.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    #12;
    chk("rst_rdata", rdata_out, 0);
    chk("rst_valid", {31'd0, bus_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_write", {31'd0, bus_write}, 0);
    #10 trst = 1'b1;

    // Reset in the middle of a read that never completes
    rsp_delay = 0; rsp_err = 0;
    model_apply(8'h03, 32'h0);
    exp_req[exp_req.size()-1].len = 0;
    issue(8'h03, 32'h0);
    @(negedge tck);
    #2 trst = 1'b0;
    #1 chk("async_rst_valid", {31'd0, bus_valid}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    m_reset();
    @(negedge tck);
    #2 trst = 1'b1;
    run_cmd(8'h04, 0, 1, 0, 0);

    // Directed scenarios
    run_cmd(8'h01, 32'h1000, 1, 0, 0);
    run_cmd(8'h02, 32'hA5A5_A5A5, 3, 0, 0);
    run_cmd(8'h04, 0, 1, 0, 0);
    run_cmd(8'h06, 1, 1, 0, 0);
    run_cmd(8'h03, 0, 1, 0, 32'h11);
    run_cmd(8'h03, 0, 1, 0, 32'h22);
    run_cmd(8'h04, 0, 1, 0, 0);
    run_cmd(8'h03, 0, 0, 0, 32'hDEAD);
    run_cmd(8'h03, 0, 2, 1, 32'h33);
    run_cmd(8'h03, 0, TO, 0, 32'h44);
    run_cmd(8'h04, 0, 1, 0, 0);

    // Overrun: second WRITE edge while the first is on the bus
    rsp_delay = 3; rsp_err = 0;
    model_apply(8'h02, 32'h5555_0000);
    issue(8'h02, 32'h5555_0000);
    issue(8'h02, 32'h6666_0000);
    m_ovr = 1; m_last = 8'h02;
    wait_idle();
    #1 exp_rd.push_back(m_rdata);
    run_cmd(8'h04, 0, 1, 0, 0);
    run_cmd(8'h05, 0, 1, 0, 0);
    run_cmd(8'h04, 0, 1, 0, 0);
    run_cmd(8'h7F, 0, 1, 0, 0);
    run_cmd(8'h04, 0, 1, 0, 0);
    run_cmd(8'h04, 0, 1, 0, 0);

    // Randomized command stream
    for (int i = 0; i < 80; i++) begin
      int          r = $urandom_range(0, 9);
      logic [7:0]  op;
      if (r <= 6)      op = 8'(r);
      else if (r == 7) op = 8'h03;
      else if (r == 8) op = 8'h02;
      else             op = 8'($urandom_range(7, 255));
      run_cmd(op, $urandom, $urandom_range(0, 6), ($urandom_range(0, 3) == 0), $urandom);
    end
    run_cmd(8'h04, 0, 1, 0, 0);

    repeat (4) @(negedge tck);
    chk("req_queue_drained", exp_req.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
